// File: rtl/fifo_guarded_pkg.sv
`default_nettype none
// ============================================================================
// fifo_guarded_pkg : status-flag record and its derivation from occupancy
// Revision: 1.0
// ============================================================================
package fifo_guarded_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } status_t;

  localparam status_t c_STATUS_RST = '{full: 1'b0, almost_full: 1'b0,
                                       empty: 1'b1, almost_empty: 1'b1};

  function automatic status_t calc_status(input int unsigned cnt,
                                          input int unsigned depth,
                                          input int unsigned a_empty,
                                          input int unsigned a_full);
    status_t s;
    s.full         = (cnt == depth);
    s.almost_full  = (cnt >= depth - a_full);
    s.empty        = (cnt == 0);
    s.almost_empty = (cnt <= a_empty);
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// fifo_mem : WIDTH x DEPTH dual-port RAM, synchronous write, async read
// Revision: 1.0
// ============================================================================
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  (* syn_ramstyle = "distributed_ram" *) logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_guarded.sv
`default_nettype none
// ============================================================================
// fifo_guarded : single-clock FIFO with exact count/flags, sticky errors, FWFT
// Revision: 1.0
// ============================================================================
module fifo_guarded
  import fifo_guarded_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int A_EMPTY = 2,
  parameter int A_FULL  = 2,
  parameter int FWFT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     re,
  input  logic                     we,
  input  logic                     clr_err,
  input  logic [WIDTH-1:0]         dataIn,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     rvalid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full_flag,
  output logic                     almost_full,
  output logic                     empty_flag,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int c_AW = $clog2(DEPTH);

  generate
    if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        A_EMPTY < 0 || A_EMPTY >= DEPTH || A_FULL < 0 || A_FULL >= DEPTH ||
        (FWFT != 0 && FWFT != 1)) begin : g_param_err
      $error("fifo_guarded: illegal parameter combination");
    end
  endgenerate

  logic [c_AW:0]      r_wr_ptr;
  logic [c_AW:0]      r_rd_ptr;
  logic [c_AW:0]      r_count;
  status_t            r_status;
  logic               r_ovf;
  logic               r_udf;

  logic               w_rd_ok;
  logic               w_wr_ok;
  logic [c_AW:0]      w_count_next;
  status_t            w_status_next;
  logic [WIDTH-1:0]   w_rdata;
  logic               w_unused_ptr_msb;

  assign w_rd_ok       = re && !r_status.empty;
  // A pop on a full FIFO frees the slot the same cycle, so the push is taken.
  assign w_wr_ok       = we && (!r_status.full || w_rd_ok);
  assign w_count_next  = r_count + {{c_AW{1'b0}}, w_wr_ok} - {{c_AW{1'b0}}, w_rd_ok};
  assign w_status_next = calc_status(32'(w_count_next), DEPTH, A_EMPTY, A_FULL);

  // Pointer MSBs only carry wrap parity; occupancy is tracked in r_count.
  assign w_unused_ptr_msb = r_wr_ptr[c_AW] ^ r_rd_ptr[c_AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_status <= c_STATUS_RST;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= w_count_next;
      r_status <= w_status_next;

      if (we && !w_wr_ok)  r_ovf <= 1'b1;
      else if (clr_err)    r_ovf <= 1'b0;

      if (re && !w_rd_ok)  r_udf <= 1'b1;
      else if (clr_err)    r_udf <= 1'b0;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (c_AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_ok && !rst),
    .i_waddr (r_wr_ptr[c_AW-1:0]),
    .i_wdata (dataIn),
    .i_raddr (r_rd_ptr[c_AW-1:0]),
    .o_rdata (w_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign dataOut = w_rdata;
      assign rvalid  = !r_status.empty;
    end else begin : g_reg_read
      logic [WIDTH-1:0] r_dout;
      logic             r_rvalid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout   <= '0;
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_rd_ok;
          if (w_rd_ok) r_dout <= w_rdata;
        end
      end

      assign dataOut = r_dout;
      assign rvalid  = r_rvalid;
    end
  endgenerate

  assign count        = r_count;
  assign full_flag    = r_status.full;
  assign almost_full  = r_status.almost_full;
  assign empty_flag   = r_status.empty;
  assign almost_empty = r_status.almost_empty;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

`ifdef FORMAL
  localparam logic [c_AW:0] c_DEPTH_CNT = DEPTH[c_AW:0];
  localparam logic [c_AW:0] c_AE_CNT    = A_EMPTY[c_AW:0];
  localparam logic [c_AW:0] c_AF_CNT    = c_AW'(DEPTH - A_FULL);
  logic r_seen_rst = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) r_seen_rst <= 1'b1;
  end

  a_count_ptr: assert property (@(posedge clk) disable iff (rst || !r_seen_rst)
    r_count == r_wr_ptr - r_rd_ptr);
  a_count_max: assert property (@(posedge clk) disable iff (rst || !r_seen_rst)
    r_count <= c_DEPTH_CNT);
  a_flags: assert property (@(posedge clk) disable iff (rst || !r_seen_rst)
    (empty_flag == (r_count == '0)) && (full_flag == (r_count == c_DEPTH_CNT)) &&
    (almost_empty == (r_count <= c_AE_CNT)) && (almost_full == (r_count >= c_AF_CNT)));
  a_wr_step: assert property (@(posedge clk) disable iff (rst || !r_seen_rst)
    !$past(rst) |-> (r_wr_ptr == $past(r_wr_ptr)) || (r_wr_ptr == $past(r_wr_ptr) + 1'b1));
  a_rd_step: assert property (@(posedge clk) disable iff (rst || !r_seen_rst)
    !$past(rst) |-> (r_rd_ptr == $past(r_rd_ptr)) || (r_rd_ptr == $past(r_rd_ptr) + 1'b1));
`endif

endmodule
`default_nettype wire
